// File: rtl/fp_cmp_sched_if.sv
// Request/response bundle for the shared 96-bit FP comparator scheduler.
// The master side is the requester/consumer; the slave side is the scheduler.
interface fp_cmp_sched_if #(
  parameter int NREQ = 4,
  parameter int TAGW = 6,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [96*NREQ-1:0]   req_a;
  logic [96*NREQ-1:0]   req_b;
  logic [4*NREQ-1:0]    req_sel;
  logic [TAGW*NREQ-1:0] req_tag;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [TAGW-1:0]      resp_tag;
  logic [15:0]          resp_cond;
  logic                 resp_bit;
  logic                 resp_inv;

  modport master (
    output req_valid, req_a, req_b, req_sel, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_tag, resp_cond, resp_bit, resp_inv
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_tag, resp_ready,
    output req_ready, resp_valid, resp_id, resp_tag, resp_cond, resp_bit, resp_inv
  );
endinterface

// File: rtl/fp_cmp_sched.sv
// Round-robin scheduler sharing one 96-bit FP comparator (1/15/80 format, bias 16383,
// quiet NaN = fraction MSB set) across NREQ requesters, two-stage pipeline, sticky flags.
module fp_cmp_sched #(
  parameter int NREQ = 4,
  parameter int TAGW = 6,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_cmp_sched_if.slave        bus,
  input  logic                 flag_clr,
  output logic                 flag_inv,
  output logic                 flag_snan
);

  function automatic logic is_nan(input logic [95:0] x);
    return (x[94:80] == 15'h7FFF) && (x[79:0] != 80'd0);
  endfunction

  function automatic logic is_snan(input logic [95:0] x);
    return is_nan(x) && !x[79];
  endfunction

  // Signed-magnitude ordering: equal magnitudes with any signs are equal only when both are zero.
  function automatic logic [15:0] cond_vec(input logic [95:0] a, input logic [95:0] b);
    logic        un, eq, lt, mlt, bz;
    logic [15:0] c;
    un  = is_nan(a) | is_nan(b);
    mlt = a[94:0] < b[94:0];
    bz  = (a[94:0] == 95'd0) && (b[94:0] == 95'd0);
    eq  = !un && (bz || (a == b));
    if (a[95] != b[95]) begin
      lt = a[95] && !bz;
    end else if (a[95]) begin
      lt = b[94:0] < a[94:0];
    end else begin
      lt = mlt;
    end
    lt     = lt && !un;
    c      = 16'd0;
    c[0]   = eq;
    c[1]   = lt;
    c[2]   = lt | eq;
    c[3]   = !un & mlt;
    c[4]   = un;
    c[8]   = !eq;
    c[9]   = !un & !lt;
    c[10]  = !un & !(lt | eq);
    c[11]  = !un & !mlt;
    c[12]  = !un;
    return c;
  endfunction

  function automatic logic inv_of(input logic snan, input logic un, input logic [3:0] sel);
    return snan | (un & ((sel == 4'd1) || (sel == 4'd2) || (sel == 4'd9) || (sel == 4'd10)));
  endfunction

  logic            s0_valid_q, s0_valid_d;
  logic [95:0]     s0_a_q, s0_b_q;
  logic [3:0]      s0_sel_q;
  logic [TAGW-1:0] s0_tag_q;
  logic [IDW-1:0]  s0_id_q;
  logic [IDW-1:0]  rr_q, rr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [15:0]     s1_cond_q;
  logic            s1_bit_q, s1_inv_q;
  logic [IDW-1:0]  s1_id_q;
  logic [TAGW-1:0] s1_tag_q;
  logic            flag_inv_q, flag_inv_d, flag_snan_q, flag_snan_d;

  logic            s1_adv_s, s0_load_s, gnt_any_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic [95:0]     mux_a_s, mux_b_s;
  logic [3:0]      mux_sel_s;
  logic [TAGW-1:0] mux_tag_s;
  logic [15:0]     cmp_cond_s;
  logic            cmp_snan_s, cmp_inv_s;

  assign s1_adv_s  = s0_valid_q & (!s1_valid_q | bus.resp_ready);
  assign s0_load_s = !s0_valid_q | s1_adv_s;

  // First pending requester at or after rr_q; lower k wins since it is assigned last.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_any_s = 1'b0;
    gnt_idx_s = {IDW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (bus.req_valid[IDW'(idx)]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = IDW'(idx);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    gnt_any_s = gnt_any_s & s0_load_s & rst_n;
  end

  assign bus.req_ready = gnt_any_s ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s) : {NREQ{1'b0}};

  always_comb begin
    mux_a_s   = 96'd0;
    mux_b_s   = 96'd0;
    mux_sel_s = 4'd0;
    mux_tag_s = {TAGW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_s == IDW'(i)) begin
        mux_a_s   = bus.req_a[96*i +: 96];
        mux_b_s   = bus.req_b[96*i +: 96];
        mux_sel_s = bus.req_sel[4*i +: 4];
        mux_tag_s = bus.req_tag[TAGW*i +: TAGW];
      end else begin
        mux_a_s   = mux_a_s;
      end
    end
  end

  assign cmp_cond_s = cond_vec(s0_a_q, s0_b_q);
  assign cmp_snan_s = is_snan(s0_a_q) | is_snan(s0_b_q);
  assign cmp_inv_s  = inv_of(cmp_snan_s, cmp_cond_s[4], s0_sel_q);

  // flag_clr wins over a same-cycle event, which is then lost.
  always_comb begin
    s0_valid_d = gnt_any_s ? 1'b1 : (s1_adv_s ? 1'b0 : s0_valid_q);
    s1_valid_d = s1_adv_s ? 1'b1 : (bus.resp_ready ? 1'b0 : s1_valid_q);
    if (gnt_any_s) begin
      rr_d = (int'(gnt_idx_s) == NREQ - 1) ? {IDW{1'b0}} : IDW'(int'(gnt_idx_s) + 1);
    end else begin
      rr_d = rr_q;
    end
    if (flag_clr) begin
      flag_inv_d  = 1'b0;
      flag_snan_d = 1'b0;
    end else if (s1_adv_s) begin
      flag_inv_d  = flag_inv_q | cmp_inv_s;
      flag_snan_d = flag_snan_q | cmp_snan_s;
    end else begin
      flag_inv_d  = flag_inv_q;
      flag_snan_d = flag_snan_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      rr_q        <= {IDW{1'b0}};
      flag_inv_q  <= 1'b0;
      flag_snan_q <= 1'b0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s1_valid_q  <= s1_valid_d;
      rr_q        <= rr_d;
      flag_inv_q  <= flag_inv_d;
      flag_snan_q <= flag_snan_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_a_q   <= 96'd0;
      s0_b_q   <= 96'd0;
      s0_sel_q <= 4'd0;
      s0_tag_q <= {TAGW{1'b0}};
      s0_id_q  <= {IDW{1'b0}};
    end else if (gnt_any_s) begin
      s0_a_q   <= mux_a_s;
      s0_b_q   <= mux_b_s;
      s0_sel_q <= mux_sel_s;
      s0_tag_q <= mux_tag_s;
      s0_id_q  <= gnt_idx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_cond_q <= 16'd0;
      s1_bit_q  <= 1'b0;
      s1_inv_q  <= 1'b0;
      s1_id_q   <= {IDW{1'b0}};
      s1_tag_q  <= {TAGW{1'b0}};
    end else if (s1_adv_s) begin
      s1_cond_q <= cmp_cond_s;
      s1_bit_q  <= cmp_cond_s[s0_sel_q];
      s1_inv_q  <= cmp_inv_s;
      s1_id_q   <= s0_id_q;
      s1_tag_q  <= s0_tag_q;
    end
  end

  assign bus.resp_valid = s1_valid_q;
  assign bus.resp_id    = s1_id_q;
  assign bus.resp_tag   = s1_tag_q;
  assign bus.resp_cond  = s1_cond_q;
  assign bus.resp_bit   = s1_bit_q;
  assign bus.resp_inv   = s1_inv_q;
  assign flag_inv       = flag_inv_q;
  assign flag_snan      = flag_snan_q;

endmodule
